// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform controller slice.
package dt_pkg;

    localparam int IMG_W     = 128;
    localparam int ROM_WORDS = 1024;
    localparam int RES_AW    = 14;
    localparam int STI_AW    = 10;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_WR,
        FWD,
        BWD,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LOAD,
        SEL_FWD,
        SEL_BWD
    } res_sel_t;

endpackage

// File: rtl/dt_res_mux.sv
// Result-RAM port multiplexer: picks the load path, one of the two engines, or nothing.
module dt_res_mux
    import dt_pkg::*;
(
    input  res_sel_t              sel,
    input  logic [RES_AW-1:0]     load_addr,
    input  logic [7:0]            load_do,
    input  logic [RES_AW-1:0]     res_addr_for,
    input  logic [7:0]            res_do_for,
    input  logic                  for_done,
    input  logic [RES_AW-1:0]     res_addr_bwd,
    input  logic [7:0]            res_do_bwd,
    input  logic                  bwd_done,
    output logic                  res_rd,
    output logic                  res_wr,
    output logic [RES_AW-1:0]     res_addr,
    output logic [7:0]            res_do
);

    always_comb begin
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        case (sel)
            SEL_LOAD: begin
                res_wr   = 1'b1;
                res_addr = load_addr;
                res_do   = load_do;
            end
            // An engine reads until it reports its result, then writes.
            SEL_FWD: begin
                res_wr   = for_done;
                res_rd   = !for_done;
                res_addr = res_addr_for;
                res_do   = res_do_for;
            end
            SEL_BWD: begin
                res_wr   = bwd_done;
                res_rd   = !bwd_done;
                res_addr = res_addr_bwd;
                res_do   = res_do_bwd;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dt_ctrl.sv
// Distance-transform sequencer: unpacks the STI ROM into the result RAM, then
// runs the forward and backward engines and reports completion.
module dt_ctrl #(
    parameter int IMG_W     = dt_pkg::IMG_W,
    parameter int ROM_WORDS = dt_pkg::ROM_WORDS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      done,
    output logic                      eng_reset,
    output logic                      sti_rd,
    output logic [dt_pkg::STI_AW-1:0] sti_addr,
    input  logic [15:0]               sti_di,
    output logic                      res_rd,
    output logic                      res_wr,
    output logic [dt_pkg::RES_AW-1:0] res_addr,
    output logic [7:0]                res_do,
    output logic                      for_load_en,
    output logic                      for_en,
    input  logic                      for_load_done,
    input  logic                      for_done,
    input  logic                      for_op_done,
    input  logic [dt_pkg::RES_AW-1:0] res_addr_for,
    input  logic [7:0]                res_do_for,
    output logic                      bwd_load_en,
    output logic                      bwd_en,
    input  logic                      bwd_load_done,
    input  logic                      bwd_done,
    input  logic                      bwd_op_done,
    input  logic [dt_pkg::RES_AW-1:0] res_addr_bwd,
    input  logic [7:0]                res_do_bwd
);

    import dt_pkg::*;

    localparam int AW = 2 * $clog2(IMG_W);
    localparam logic [STI_AW-1:0] LAST_W = STI_AW'(ROM_WORDS - 1);

    state_t            state_q, state_d;
    logic [STI_AW-1:0] w_q, w_d;
    logic [3:0]        k_q, k_d;
    logic [15:0]       word_q, word_d;
    res_sel_t          res_sel;
    logic [AW-1:0]     load_addr;
    logic              load_bit;

    // The engines' load-done flags carry no sequencing meaning here.
    logic unused_status;
    assign unused_status = for_load_done ^ bwd_load_done;

    assign load_addr = {w_q, k_q};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        k_d         = k_q;
        word_d      = word_q;
        done        = 1'b0;
        eng_reset   = 1'b0;
        sti_rd      = 1'b0;
        sti_addr    = '0;
        for_load_en = 1'b0;
        for_en      = 1'b0;
        bwd_load_en = 1'b0;
        bwd_en      = 1'b0;
        res_sel     = SEL_NONE;
        // ROM data is live only in the first bit cycle; later bits come from the copy.
        load_bit    = (k_q == 4'd0) ? sti_di[15] : word_q[4'd15 - k_q];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_RD;
                    w_d     = '0;
                    k_d     = '0;
                end
            end
            LD_RD: begin
                eng_reset = 1'b1;
                sti_rd    = 1'b1;
                sti_addr  = w_q;
                k_d       = '0;
                state_d   = LD_WR;
            end
            LD_WR: begin
                eng_reset = 1'b1;
                res_sel   = SEL_LOAD;
                k_d       = k_q + 4'd1;
                if (k_q == 4'd0) word_d = sti_di;
                if (k_q == 4'd15) begin
                    if (w_q == LAST_W) begin
                        state_d = FWD;
                    end else begin
                        w_d     = w_q + 1'b1;
                        state_d = LD_RD;
                    end
                end
            end
            FWD: begin
                eng_reset   = 1'b1;
                for_load_en = 1'b1;
                for_en      = 1'b1;
                res_sel     = SEL_FWD;
                if (for_op_done) state_d = BWD;
            end
            BWD: begin
                eng_reset   = 1'b1;
                bwd_load_en = 1'b1;
                bwd_en      = 1'b1;
                res_sel     = SEL_BWD;
                if (bwd_op_done) state_d = FIN;
            end
            FIN: begin
                done = 1'b1;
                if (start) begin
                    state_d = LD_RD;
                    w_d     = '0;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; word_q is a single register, so it is reset too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            k_q     <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            k_q     <= k_d;
            word_q  <= word_d;
        end
    end

    dt_res_mux u_res_mux (
        .sel          (res_sel),
        .load_addr    (load_addr),
        .load_do      ({7'b0, load_bit}),
        .res_addr_for (res_addr_for),
        .res_do_for   (res_do_for),
        .for_done     (for_done),
        .res_addr_bwd (res_addr_bwd),
        .res_do_bwd   (res_do_bwd),
        .bwd_done     (bwd_done),
        .res_rd       (res_rd),
        .res_wr       (res_wr),
        .res_addr     (res_addr),
        .res_do       (res_do)
    );

endmodule

// File: tb/tb_dt_ctrl.sv
// Directed bench for dt_ctrl: ROM model, load-write scoreboard and stubbed engines.
module tb_dt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done, eng_reset;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di;
    logic        res_rd, res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic        for_load_en, for_en, for_load_done, for_done, for_op_done;
    logic [13:0] res_addr_for;
    logic [7:0]  res_do_for;
    logic        bwd_load_en, bwd_en, bwd_load_done, bwd_done, bwd_op_done;
    logic [13:0] res_addr_bwd;
    logic [7:0]  res_do_bwd;

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  exp_w = 0;
    int  n_wr  = 0;

    always #5 clk = ~clk;

    dt_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .done          (done),
        .eng_reset     (eng_reset),
        .sti_rd        (sti_rd),
        .sti_addr      (sti_addr),
        .sti_di        (sti_di),
        .res_rd        (res_rd),
        .res_wr        (res_wr),
        .res_addr      (res_addr),
        .res_do        (res_do),
        .for_load_en   (for_load_en),
        .for_en        (for_en),
        .for_load_done (for_load_done),
        .for_done      (for_done),
        .for_op_done   (for_op_done),
        .res_addr_for  (res_addr_for),
        .res_do_for    (res_do_for),
        .bwd_load_en   (bwd_load_en),
        .bwd_en        (bwd_en),
        .bwd_load_done (bwd_load_done),
        .bwd_done      (bwd_done),
        .bwd_op_done   (bwd_op_done),
        .res_addr_bwd  (res_addr_bwd),
        .res_do_bwd    (res_do_bwd)
    );

    function automatic logic [15:0] rom_word(input int i);
        int v;
        if (i == 0) return 16'hA001;
        v = i * 40503 + 4660;
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, answer ROM reads and score load writes.
    task automatic step();
        logic [15:0] wv;
        logic [9:0]  wa;
        wr_t         e;
        @(negedge clk);
        cyc++;
        check("exclusive", {30'b0, res_wr & res_rd, for_en & bwd_en}, 32'd0);
        if (sti_rd) begin
            check("sti_addr", {22'b0, sti_addr}, exp_w);
            wv = rom_word(exp_w);
            wa = exp_w[9:0];
            for (int k = 0; k < 16; k++) begin
                e.addr = {wa, k[3:0]};
                e.data = {7'b0, wv[15-k]};
                sb.push_back(e);
            end
            sti_di = rom_word(int'(sti_addr));
            exp_w++;
        end
        if (res_wr && !for_en && !bwd_en) begin
            if (sb.size() == 0) begin
                check("spurious_wr", {31'b0, res_wr}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ld_addr", {18'b0, res_addr}, {18'b0, e.addr});
                check("ld_data", {24'b0, res_do}, {24'b0, e.data});
                n_wr++;
            end
        end
    endtask

    initial begin
        logic [15:0] pat;
        pat           = 16'b1010_0000_0000_0001;
        reset         = 1'b0;
        start         = 1'b0;
        sti_di        = '0;
        for_load_done = 1'b0;
        for_done      = 1'b0;
        for_op_done   = 1'b0;
        res_addr_for  = '0;
        res_do_for    = '0;
        bwd_load_done = 1'b0;
        bwd_done      = 1'b0;
        bwd_op_done   = 1'b0;
        res_addr_bwd  = '0;
        res_do_bwd    = '0;

        #1;
        check("rst_outputs", {done, eng_reset, sti_rd, res_rd, res_wr, for_en, bwd_en}, 32'd0);
        check("rst_addr", {res_addr, sti_addr}, 32'd0);
        repeat (3) step();
        reset = 1'b1;
        step();
        check("idle_outputs", {done, eng_reset, sti_rd, res_wr, for_load_en, bwd_load_en}, 32'd0);

        // First run, aborted by reset inside word 5's write burst.
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        while (cyc < 90) step();
        check("pre_rst_wr", {31'b0, res_wr}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", {done, eng_reset, sti_rd, res_rd, res_wr, for_en, bwd_en}, 32'd0);
        check("async_rst_bus", {res_addr, sti_addr}, 32'd0);
        check("async_rst_do", {24'b0, res_do}, 32'd0);
        sb.delete();
        exp_w = 0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Full load from word 0.
        start = 1'b1;
        cyc   = 0;
        n_wr  = 0;
        step();
        start = 1'b0;
        check("c1_sti_rd", {31'b0, sti_rd}, 32'd1);
        check("c1_sti_addr", {22'b0, sti_addr}, 32'd0);
        check("c1_eng_reset", {31'b0, eng_reset}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            step();
            check("w0_wr", {30'b0, res_wr, sti_rd}, 32'd2);
            check("w0_addr", {18'b0, res_addr}, k);
            check("w0_data", {24'b0, res_do}, {31'b0, pat[15-k]});
        end
        while (cyc < 499) step();
        start = 1'b1;
        step();
        start = 1'b0;
        res_addr_for = 14'h0155;
        while (cyc < 17408) step();
        check("last_wr", {31'b0, res_wr}, 32'd1);
        check("last_addr", {18'b0, res_addr}, 32'd16383);
        check("n_writes", n_wr, 32'd16384);

        step();
        check("fwd_en", {for_load_en, for_en, bwd_load_en, bwd_en, eng_reset}, 32'b11001);
        check("sb_drained", sb.size(), 32'd0);
        check("fwd_rd", {30'b0, res_rd, res_wr}, 32'd2);
        check("fwd_rd_addr", {18'b0, res_addr}, 32'h155);

        for_done     = 1'b1;
        res_addr_for = 14'h0081;
        res_do_for   = 8'h03;
        #1;
        check("fwd_wr", {30'b0, res_wr, res_rd}, 32'd2);
        check("fwd_wr_addr", {18'b0, res_addr}, 32'h81);
        check("fwd_wr_do", {24'b0, res_do}, 32'h03);
        for_done    = 1'b0;
        for_op_done = 1'b1;
        step();
        for_op_done = 1'b0;
        check("bwd_en", {for_load_en, for_en, bwd_load_en, bwd_en, eng_reset}, 32'b00111);

        res_addr_bwd = 14'h2A5A;
        res_do_bwd   = 8'h07;
        #1;
        check("bwd_rd", {30'b0, res_rd, res_wr}, 32'd2);
        check("bwd_rd_addr", {18'b0, res_addr}, 32'h2A5A);
        bwd_done = 1'b1;
        #1;
        check("bwd_wr", {30'b0, res_wr, res_rd}, 32'd2);
        check("bwd_wr_do", {24'b0, res_do}, 32'h07);
        bwd_done = 1'b0;

        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored", {30'b0, bwd_en, done}, 32'd2);
        repeat (2) step();
        check("bwd_hold", {31'b0, bwd_en}, 32'd1);
        bwd_op_done = 1'b1;
        step();
        bwd_op_done = 1'b0;
        check("fin_done", {done, eng_reset, bwd_en, res_wr, res_rd}, 32'b10000);
        check("fin_addr", {18'b0, res_addr}, 32'd0);
        repeat (3) step();
        check("done_held", {31'b0, done}, 32'd1);

        // Restart from FIN.
        start = 1'b1;
        cyc   = 0;
        exp_w = 0;
        n_wr  = 0;
        sb.delete();
        step();
        start = 1'b0;
        check("rerun_done", {31'b0, done}, 32'd0);
        check("rerun_sti", {21'b0, sti_rd, sti_addr}, 32'h400);
        repeat (40) step();
        check("rerun_writes", n_wr, 32'd38);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dt_ctrl.md
# dt_ctrl

Top-level sequencer for the distance-transform datapath. It unpacks the 1-bit-per-pixel source image from the 16-bit STI ROM into the 128×128 result RAM, then runs the forward-pass engine and the backward-pass engine in turn. It owns the single result-RAM port and multiplexes it between its own load writes and the two engines. It raises `done` when the transform is complete.

## Interface
Parameters:
- `IMG_W`, 128: image width and height in pixels; res address width is 2·log2(IMG_W) = 14.
- `ROM_WORDS`, 1024: number of STI words, equal to IMG_W²/16.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset; one clock, asynchronous, active-low
- `start`  in  1  single-cycle start pulse; honoured only in IDLE and FIN
- `done`  out  1  transform complete; held until the next accepted `start`
- `eng_reset`  out  1  active-low reset to both engines
- `sti_rd`  out  1  ROM read strobe
- `sti_addr`  out  10  ROM word address
- `sti_di`  in  16  ROM data, valid in the cycle after `sti_rd`
- `res_rd`  out  1  RAM read strobe
- `res_wr`  out  1  RAM write strobe
- `res_addr`  out  14  RAM address
- `res_do`  out  8  RAM write data
- `for_load_en`, `for_en`  out  1  forward engine enables
- `for_load_done`, `for_done`, `for_op_done`  in  1  forward engine status
- `res_addr_for`  in  14  forward engine address
- `res_do_for`  in  8  forward engine write data
- `bwd_load_en`, `bwd_en`  out  1  backward engine enables
- `bwd_load_done`, `bwd_done`, `bwd_op_done`  in  1  backward engine status
- `res_addr_bwd`  in  14  backward engine address
- `res_do_bwd`  in  8  backward engine write data

## Operation
- FSM states:
  - IDLE: wait for `start`.
  - LD_RD: drive `sti_rd`=1 with `sti_addr`=word counter `w`.
  - LD_WR: 16 cycles, bit index `k`=0..15.
    - `res_wr`=1, `res_addr`={`w`,`k`[3:0]}, `res_do`={7'b0, bit}.
    - Bit is `sti_di`[15] when `k`=0, otherwise `word_q`[15-k].
    - `word_q` captures `sti_di` at the end of the `k`=0 cycle.
    - After `k`=15: if `w`=1023 go to FWD, else increment `w` and go to LD_RD.
  - FWD: `for_load_en`=`for_en`=1. The RAM port follows the forward engine:
    - `res_addr`=`res_addr_for`, `res_do`=`res_do_for`.
    - `res_wr`=`for_done`, `res_rd`=!`for_done`.
    - Go to BWD on the first cycle `for_op_done`=1.
  - BWD: mirror of FWD using the `bwd_*` signals. Go to FIN on `bwd_op_done`=1.
  - FIN: `done`=1. A `start` here goes to LD_RD, clears `done` and `w`.
- `eng_reset`=1 only in LD_RD, LD_WR, FWD and BWD. The engines are therefore held in reset in IDLE and FIN, which clears their sticky `*_op_done` flags before a rerun.
- In every state not listed above as driving a signal, all strobes and enables are 0, and `res_addr`/`res_do`/`sti_addr` are 0.
- Pixel mapping is MSB-first: word `w` bit 15 is pixel 16·`w`. Border pixels are written exactly as supplied.
- `start` outside IDLE and FIN is ignored.

## Timing
- Every output is 0 during and after reset, except `eng_reset`=0. FSM returns to IDLE, `w`=`k`=0.
- Reset is asynchronous and may assert mid-phase. The FSM goes to IDLE immediately and no further RAM writes are issued.
- `start` sampled at edge 0 → LD_RD in cycle 1 → first RAM write in cycle 2.
- One word takes 17 cycles. The load phase lasts 17408 cycles.
- FWD is entered in cycle 17409 with `for_load_en`=1 that same cycle.
- Phase handoffs take 1 cycle: a status bit high at edge n changes state at edge n.
- Never more than one of `res_wr`/`res_rd` is high. Never more than one engine is enabled.
- `done` rises in the cycle after `bwd_op_done` is sampled.

## Structure
- Shared package `dt_pkg` holds:
  - the state enum (IDLE, LD_RD, LD_WR, FWD, BWD, FIN),
  - `IMG_W`, `ROM_WORDS`,
  - address widths 14 and 10.
- Natural sub-module `dt_res_mux`: a combinational RAM-port mux selected by state (load / forward / backward / none). The FSM, counters and `word_q` stay in `dt_ctrl`.

## Test plan
- Reset asserted mid-LD_WR at `w`=5 → outputs zero asynchronously, `eng_reset`=0. After release, `start` restarts at `sti_addr`=0.
- ROM word 0 = 16'hA001 → writes to addr 0..15 carry data 1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,1 in cycles 2..17. `sti_rd` is high only in cycle 1.
- Full load → last write at `res_addr`=16383 in cycle 17408. `for_load_en`=1 in cycle 17409 and `bwd_load_en`=0.
- Stub forward engine with `for_done`=1, `res_addr_for`=14'h0081, `res_do_for`=8'h03 → `res_wr`=1, `res_addr`=0x0081, `res_do`=0x03, `res_rd`=0.
- `for_op_done` pulse → BWD next cycle. `bwd_op_done` → `done`=1, `eng_reset`=0. Mid-run `start` is ignored.
- `start` in FIN → `done`=0 next cycle and the load phase reruns from `sti_addr`=0.
